// File: rtl/mod_accumulate.sv
// fp16 accumulator: sums N_TERMS products through an align/add/normalize FSM.
// A term takes 4 cycles to be absorbed; out_Busy high for 3 of them, terms offered while busy are dropped.
module mod_accumulate #(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_Value,
  input  logic        in_En,
  input  logic        in_Clear,
  output logic [15:0] out_Sum,
  output logic        out_Ready,
  output logic        out_Busy
);

  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  state_t        state;
  logic [15:0]   acc;
  logic [15:0]   opnd;
  logic [CW-1:0] cnt;
  logic          big_sgn;
  logic          sub_op;
  logic [4:0]    big_exp;
  logic [10:0]   big_man;
  logic [10:0]   sml_man;
  logic [11:0]   sum;

  // exponent-0 operands count as exact zero, so they never win the compare
  logic        a_zero, b_zero, a_big, l_zero, s_zero;
  logic [14:0] a_mag, b_mag;
  logic [15:0] l_op, s_op;
  logic [4:0]  exp_diff;
  logic [10:0] l_man, s_man;

  always_comb begin
    a_zero   = (acc[14:10] == 5'd0);
    b_zero   = (opnd[14:10] == 5'd0);
    a_mag    = a_zero ? 15'd0 : acc[14:0];
    b_mag    = b_zero ? 15'd0 : opnd[14:0];
    a_big    = (a_mag >= b_mag);
    l_op     = a_big ? acc : opnd;
    s_op     = a_big ? opnd : acc;
    l_zero   = a_big ? a_zero : b_zero;
    s_zero   = a_big ? b_zero : a_zero;
    exp_diff = l_op[14:10] - s_op[14:10];
    l_man    = l_zero ? 11'd0 : {1'b1, l_op[9:0]};
    s_man    = (s_zero || exp_diff >= 5'd11) ? 11'd0 : ({1'b1, s_op[9:0]} >> exp_diff);
  end

  function automatic logic [3:0] lzc11(input logic [10:0] m);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (m[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  logic [3:0]        lz;
  logic signed [6:0] e_n;
  logic [10:0]       m_n;
  logic [15:0]       res;

  always_comb begin
    lz = lzc11(sum[10:0]);
    if (sum[11]) begin
      e_n = $signed({2'b00, big_exp}) + 7'sd1;
      m_n = sum[11:1];
    end else begin
      e_n = $signed({2'b00, big_exp}) - $signed({3'b000, lz});
      m_n = sum[10:0] << lz;
    end
    if (sum == 12'd0 || e_n < 7'sd1) res = 16'h0000;
    else if (e_n > 7'sd30)           res = {big_sgn, 15'h7BFF};
    else                             res = {big_sgn, e_n[4:0], m_n[9:0]};
  end

  assign out_Busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      opnd      <= 16'h0000;
      cnt       <= '0;
      big_sgn   <= 1'b0;
      sub_op    <= 1'b0;
      big_exp   <= 5'd0;
      big_man   <= 11'd0;
      sml_man   <= 11'd0;
      sum       <= 12'd0;
      out_Sum   <= 16'h0000;
      out_Ready <= 1'b0;
    end else begin
      out_Ready <= 1'b0;
      if (in_Clear) begin
        state <= IDLE;
        acc   <= 16'h0000;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_En) begin
              opnd  <= in_Value;
              state <= ALIGN;
            end
          end
          ALIGN: begin
            big_sgn <= l_op[15];
            sub_op  <= l_op[15] ^ s_op[15];
            big_exp <= l_op[14:10];
            big_man <= l_man;
            sml_man <= s_man;
            state   <= ADD;
          end
          ADD: begin
            sum   <= sub_op ? ({1'b0, big_man} - {1'b0, sml_man})
                            : ({1'b0, big_man} + {1'b0, sml_man});
            state <= NORM;
          end
          NORM: begin
            if (cnt == CW'(N_TERMS - 1)) begin
              out_Sum   <= res;
              out_Ready <= 1'b1;
              acc       <= 16'h0000;
              cnt       <= '0;
            end else begin
              acc <= res;
              cnt <= cnt + CW'(1);
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
